regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 64x32 register file between two write-back requesters: A (ALU result) and B (memory load).
- Round-robin arbitration with valid/ready handshakes on each requester.
- One registered output stage drives the register file's wrt/rd/dataIn pins.
- Exposes an in-flight query so read-side logic can detect a pending write to a source register.

Parameters:
- ADDR_W, 6, register address width (64 registers).
- DATA_W, 32, write data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- a_valid  input  1  requester A has a write pending.
- a_rd  input  ADDR_W  requester A destination register.
- a_data  input  DATA_W  requester A write data.
- a_ready  output  1  A's request is accepted this cycle (combinational).
- b_valid  input  1  requester B has a write pending.
- b_rd  input  ADDR_W  requester B destination register.
- b_data  input  DATA_W  requester B write data.
- b_ready  output  1  B's request is accepted this cycle (combinational).
- hold  input  1  register file cannot accept a write this cycle.
- wrt  output  1  write enable to the register file (registered).
- rd  output  ADDR_W  write address to the register file (registered).
- dataIn  output  DATA_W  write data to the register file (registered).
- q_rs  input  ADDR_W  register address for the in-flight query.
- q_busy  output  1  high when wrt is high and rd equals q_rs (combinational).
- last_grant  output  1  0 = A granted most recently, 1 = B (registered).

Behaviour:
- Reset (rst high at posedge): wrt=0, rd=0, dataIn=0, last_grant=1 (so A wins the first contest). During rst, a_ready=b_ready=0.
- Output stage: one slot, holding {wrt, rd, dataIn}.
  - The slot is free when wrt=0 or hold=0.
  - The slot drains (write commits to the register file) on any posedge where wrt=1 and hold=0.
- Accept: only when the slot is free.
  - Only a_valid high: a_ready=1.
  - Only b_valid high: b_ready=1.
  - Both high: grant the requester not equal to last_grant.
  - At most one ready is high per cycle.
  - A ready is never high while its valid is low.
- On accept at posedge: wrt<=1, rd<=granted rd, dataIn<=granted data, last_grant<=granted id.
- No accept and slot free: wrt<=0. rd and dataIn keep their old values (don't-care).
- hold=1 with wrt=1:
  - All output registers are held.
  - Both ready signals stay low.
  - Requesters must keep valid, rd and data stable until accepted.
- Latency: accept at edge N, wrt high from edge N to edge N+1 (exactly one cycle when hold is low). Sustained throughput is one write per cycle.
- Arbitration state machine, encoded by last_grant:
  - PRI_A (last_grant=1): a contest grants A and moves to PRI_B.
  - PRI_B (last_grant=0): a contest grants B and moves to PRI_A.
  - An uncontested grant also sets last_grant to the granted id.
- Same rd from A and B on consecutive grants: both writes are issued in grant order; the later one wins in the register file. No merging.
- q_busy is purely combinational from wrt, rd and q_rs. It is 0 while wrt=0.
- Reset mid-operation: a write held in the slot is dropped (wrt=0 at the next edge). Any accept in the same cycle is ignored.
- No write is ever issued with wrt high and X on rd or dataIn.

Optional Feature:
- Macro: REGFILE_WB_ZERO_DROP_EN.
- Defined:
  - A request with rd==0 is still accepted (ready asserted per normal arbitration).
  - wrt stays 0 for it, so register 0 is never written.
  - last_grant still updates.
  - q_busy for q_rs=0 is always 0.
- Not defined: rd==0 is treated like any other register.

Test Plan:
- Reset, then a_valid=1, a_rd=5, a_data=0x11 for one cycle -> a_ready=1 that cycle; next cycle wrt=1, rd=5, dataIn=0x11; the cycle after, wrt=0; last_grant=0.
- After reset, both valid (a_rd=2/0xAA, b_rd=3/0xBB) held for 2 cycles -> A granted first, then B. Outputs are rd=2 then rd=3 on consecutive cycles, last_grant goes 0 then 1.
- Continuous contention for 6 cycles -> grants strictly alternate A,B,A,B,A,B; no requester waits more than 1 cycle.
- Slot holds rd=7/0x55 with hold=1 for 3 cycles and a_valid=1 -> wrt, rd=7, dataIn=0x55 stable and a_ready=0 for 3 cycles. On the cycle hold drops: a_ready=1, and the next output is A's write.
- wrt=1, rd=9: q_rs=9 -> q_busy=1; q_rs=8 -> q_busy=0. rst asserted while wrt=1 -> wrt=0 next cycle, q_busy=0.
- With REGFILE_WB_ZERO_DROP_EN defined: a_valid=1, a_rd=0 -> a_ready=1, wrt stays 0, last_grant=0. Without the macro: wrt=1, rd=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin A/B write-back arbiter for the register file write port; REGFILE_WB_ZERO_DROP_EN suppresses writes to register 0
module regfile_wb_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              hold,
  output logic              wrt,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] dataIn,
  input  logic [ADDR_W-1:0] q_rs,
  output logic              q_busy,
  output logic              last_grant
);
  typedef enum logic {PRI_B = 1'b0, PRI_A = 1'b1} pri_t;
  pri_t state, state_nx;
  logic slot_free, grant_b, accept, wrt_nx;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  assign slot_free = !wrt || !hold;
  assign last_grant = state;
  always_ff @(posedge clk)
    if (rst) state <= PRI_A;
    else state <= state_nx;
  always_comb begin
    grant_b = b_valid && (!a_valid || state == PRI_B);
    a_ready = !rst && slot_free && a_valid && !grant_b;
    b_ready = !rst && slot_free && grant_b;
    accept = a_ready || b_ready;
    state_nx = accept ? (grant_b ? PRI_A : PRI_B) : state;
    sel_rd = grant_b ? b_rd : a_rd;
    sel_data = grant_b ? b_data : a_data;
  end
`ifdef REGFILE_WB_ZERO_DROP_EN
  assign wrt_nx = sel_rd != '0;
  assign q_busy = wrt && rd == q_rs && q_rs != '0;
`else
  assign wrt_nx = 1'b1;
  assign q_busy = wrt && rd == q_rs;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      wrt <= 1'b0;
      rd <= '0;
      dataIn <= '0;
    end else if (accept) begin
      wrt <= wrt_nx;
      rd <= sel_rd;
      dataIn <= sel_data;
    end else if (slot_free) wrt <= 1'b0;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks against a behavioural model of the arbiter
module tb_regfile_wb_arbiter;
`ifdef REGFILE_WB_ZERO_DROP_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, hold = 1'b0;
  logic [5:0] a_rd = '0, b_rd = '0, q_rs = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic a_ready, b_ready, wrt, q_busy, last_grant;
  logic [5:0] rd;
  logic [31:0] dataIn;
  int checks = 0, failures = 0;
  logic m_wrt, m_lg, ea, eb, free;
  logic [5:0] m_rd;
  logic [31:0] m_data;
  always #5 clk = ~clk;
  regfile_wb_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .hold(hold), .wrt(wrt), .rd(rd), .dataIn(dataIn),
    .q_rs(q_rs), .q_busy(q_busy), .last_grant(last_grant)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    free = !m_wrt || !hold;
    ea = !rst && free && a_valid && (!b_valid || m_lg);
    eb = !rst && free && b_valid && (!a_valid || !m_lg);
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    chk("q_busy", q_busy, m_wrt && m_rd == q_rs && !(ZD && q_rs == 0));
    @(posedge clk);
    if (rst) begin
      m_wrt = 0; m_rd = 0; m_data = 0; m_lg = 1;
    end else if (ea || eb) begin
      m_rd = ea ? a_rd : b_rd;
      m_data = ea ? a_data : b_data;
      m_wrt = !(ZD && m_rd == 0);
      m_lg = eb;
    end else if (free) m_wrt = 0;
    #1;
    chk("wrt", wrt, m_wrt);
    chk("last_grant", last_grant, m_lg);
    if (m_wrt) begin
      chk("rd", rd, m_rd);
      chk("dataIn", dataIn, m_data);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    m_wrt = 0; m_rd = 0; m_data = 0; m_lg = 1;
    chk("rst_wrt", wrt, 0);
    chk("rst_rd", rd, 0);
    chk("rst_dataIn", dataIn, 0);
    chk("rst_last_grant", last_grant, 1);
    chk("rst_a_ready", a_ready, 0);
    rst = 0;
    a_valid = 1; a_rd = 5; a_data = 32'h11;
    cyc();
    a_valid = 0;
    chk("single_rd", rd, 5);
    chk("single_data", dataIn, 32'h11);
    cyc();
    chk("single_wrt_off", wrt, 0);
    chk("single_lg", last_grant, 0);
    rst = 1;
    cyc();
    rst = 0;
    a_valid = 1; a_rd = 2; a_data = 32'hAA;
    b_valid = 1; b_rd = 3; b_data = 32'hBB;
    cyc();
    chk("contest1_rd", rd, 2);
    chk("contest1_lg", last_grant, 0);
    cyc();
    chk("contest2_rd", rd, 3);
    chk("contest2_lg", last_grant, 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("alternate_lg", last_grant, i % 2);
    end
    b_valid = 0;
    a_valid = 1; a_rd = 7; a_data = 32'h55;
    cyc();
    a_rd = 1; a_data = 32'h66; hold = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_rd", rd, 7);
      chk("hold_data", dataIn, 32'h55);
    end
    hold = 0;
    cyc();
    a_valid = 0;
    chk("after_hold_rd", rd, 1);
    chk("after_hold_data", dataIn, 32'h66);
    a_valid = 1; a_rd = 9; a_data = 32'h99;
    cyc();
    a_valid = 0; hold = 1; q_rs = 9;
    #1 chk("q_busy_hit", q_busy, 1);
    q_rs = 8;
    #1 chk("q_busy_miss", q_busy, 0);
    q_rs = 9; rst = 1;
    cyc();
    rst = 0; hold = 0;
    chk("rst_drop_wrt", wrt, 0);
    #1 chk("rst_drop_q_busy", q_busy, 0);
    a_valid = 1; a_rd = 0; a_data = 32'h77;
    cyc();
    a_valid = 0;
    chk("zero_wrt", wrt, ZD ? 0 : 1);
    chk("zero_lg", last_grant, 0);
    for (int i = 0; i < 400; i++) begin
      if (!a_valid) begin
        a_valid = ($urandom % 3) != 0;
        a_rd = ($urandom % 4 == 0) ? 6'd0 : 6'($urandom);
        a_data = $urandom;
      end
      if (!b_valid) begin
        b_valid = ($urandom % 3) != 0;
        b_rd = ($urandom % 4 == 0) ? 6'd0 : 6'($urandom);
        b_data = $urandom;
      end
      hold = ($urandom % 4) == 0;
      rst = ($urandom % 50) == 0;
      q_rs = ($urandom % 2) ? m_rd : 6'($urandom);
      cyc();
      if (ea) a_valid = 0;
      if (eb) b_valid = 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
